// File: rtl/bus_txn_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_txn_responder
// Description : Register-file transaction responder with programmable wait
//               states, hold/abort control and overlap detection.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_txn_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_transaction,
    input  logic              txn_write,
    input  logic [ADDR_W-1:0] txn_addr,
    input  logic [DATA_W-1:0] txn_wdata,
    input  logic [2:0]        cfg_wait,
    input  logic              hold,
    input  logic              abort,
    output logic              complete_transaction,
    output logic [DATA_W-1:0] txn_rdata,
    output logic              busy,
    output logic              overlap_error
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_next;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_overlap;
    logic              w_accept;
    logic              w_overlap;
    logic              w_commit;
    logic [DATA_W-1:0] r_regfile [c_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_overlap    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start_transaction;
            end
            S_WAIT: begin
                // A request arriving here is dropped; abort wins over hold.
                w_overlap = start_transaction;
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 3'd0;
                end else if (!hold) begin
                    w_cnt_next = r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        w_state_next = S_RESP;
                    end
                end
            end
            S_RESP: begin
                w_commit     = r_write;
                w_accept     = start_transaction;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_accept) begin
            w_cnt_next   = cfg_wait;
            w_state_next = (cfg_wait == 3'd0) ? S_RESP : S_WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 3'd0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_overlap <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_overlap <= w_overlap;
            if (w_accept) begin
                r_write <= txn_write;
                r_addr  <= txn_addr;
                r_wdata <= txn_wdata;
            end
        end
    end

    // Commit uses the fields of the finishing transaction even when a new
    // request is latched on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regfile[i] <= '0;
            end
        end else if (w_commit) begin
            r_regfile[r_addr] <= r_wdata;
        end
    end

    // Read data comes straight from the regfile so a back-to-back read sees
    // the write committed on the preceding edge.
    assign complete_transaction = (r_state == S_RESP);
    assign busy                 = (r_state == S_WAIT);
    assign overlap_error        = r_overlap;
    assign txn_rdata            = ((r_state == S_RESP) && !r_write) ? r_regfile[r_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bus_txn_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_txn_responder
// Description : Self-checking bench for bus_txn_responder with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_txn_responder;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start_transaction = 1'b0;
    logic              txn_write = 1'b0;
    logic [ADDR_W-1:0] txn_addr = '0;
    logic [DATA_W-1:0] txn_wdata = '0;
    logic [2:0]        cfg_wait = '0;
    logic              hold = 1'b0;
    logic              abort = 1'b0;
    logic              complete_transaction;
    logic [DATA_W-1:0] txn_rdata;
    logic              busy;
    logic              overlap_error;

    bus_txn_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .start_transaction    (start_transaction),
        .txn_write            (txn_write),
        .txn_addr             (txn_addr),
        .txn_wdata            (txn_wdata),
        .cfg_wait             (cfg_wait),
        .hold                 (hold),
        .abort                (abort),
        .complete_transaction (complete_transaction),
        .txn_rdata            (txn_rdata),
        .busy                 (busy),
        .overlap_error        (overlap_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int ovl_cnt = 0;
    int ovl_cyc = 0;
    int comp_cyc[$];
    logic [DATA_W-1:0] comp_data[$];

    // Model: an outstanding transaction with a count of un-held wait cycles
    logic [DATA_W-1:0] mem [2**ADDR_W];
    bit                m_ok = 1'b0;
    bit                m_wait = 1'b0;
    bit                m_resp = 1'b0;
    bit                m_write = 1'b0;
    int                m_remaining = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic              e_complete = 1'b0;
    logic              e_busy = 1'b0;
    logic              e_overlap = 1'b0;
    logic [DATA_W-1:0] e_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        m_ok = 1'b1;
        m_wait = 1'b0;
        m_resp = 1'b0;
        m_remaining = 0;
        e_complete = 1'b0;
        e_busy = 1'b0;
        e_overlap = 1'b0;
        e_rdata = '0;
    endtask

    task automatic model_step();
        bit ovl;
        bit nxt_wait;
        bit nxt_resp;
        ovl = start_transaction && m_wait;
        nxt_wait = m_wait;
        nxt_resp = 1'b0;
        if (m_resp && m_write) mem[m_addr] = m_wdata;
        if (m_wait) begin
            if (abort) begin
                nxt_wait = 1'b0;
            end else if (!hold) begin
                m_remaining--;
                if (m_remaining == 0) begin
                    nxt_wait = 1'b0;
                    nxt_resp = 1'b1;
                end
            end
        end else if (start_transaction) begin
            m_write = txn_write;
            m_addr = txn_addr;
            m_wdata = txn_wdata;
            if (cfg_wait == 3'd0) begin
                nxt_resp = 1'b1;
            end else begin
                nxt_wait = 1'b1;
                m_remaining = int'(cfg_wait);
            end
        end
        m_wait = nxt_wait;
        m_resp = nxt_resp;
        e_complete = m_resp;
        e_busy = m_wait;
        e_overlap = ovl;
        e_rdata = (m_resp && !m_write) ? mem[m_addr] : '0;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!reset && m_ok) model_step();
    end

    always @(negedge clk) begin
        if (reset) model_reset();
        if (m_ok) begin
            chk("complete", complete_transaction, e_complete);
            chk("rdata", txn_rdata, e_rdata);
            chk("busy", busy, e_busy);
            chk("overlap", overlap_error, e_overlap);
        end
        if (complete_transaction === 1'b1) begin
            comp_cyc.push_back(cyc);
            comp_data.push_back(txn_rdata);
        end
        if (busy === 1'b1) busy_cnt++;
        if (overlap_error === 1'b1) begin
            ovl_cnt++;
            ovl_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        comp_cyc.delete();
        comp_data.delete();
        busy_cnt = 0;
        ovl_cnt = 0;
    endtask

    task automatic issue(input bit w, input int a, input int d, input int c, output int k);
        start_transaction = 1'b1;
        txn_write = w;
        txn_addr = ADDR_W'(a);
        txn_wdata = DATA_W'(d);
        cfg_wait = 3'(c);
        k = cyc;
        step();
        start_transaction = 1'b0;
        txn_write = 1'b0;
        txn_addr = '0;
        txn_wdata = '0;
        cfg_wait = '0;
    endtask

    task automatic wait_comp(input string name, input int exp_cyc, input int exp_data);
        int got_c;
        logic [DATA_W-1:0] got_d;
        for (int i = 0; i < 40 && comp_cyc.size() == 0; i++) step();
        if (comp_cyc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no completion, expected one at cycle %0d", name, exp_cyc);
        end else begin
            got_c = comp_cyc.pop_front();
            got_d = comp_data.pop_front();
            chk({name, "_cycle"}, got_c, exp_cyc);
            chk({name, "_rdata"}, got_d, exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int j;
        #1 reset = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("reset_complete", complete_transaction, 0);
        chk("reset_rdata", txn_rdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overlap", overlap_error, 0);
        step();
        reset = 1'b0;
        step();

        // Read of a reset register with no wait states
        clear_log();
        issue(0, 3, 0, 0, k);
        wait_comp("rd3", k + 1, 0);
        chk("rd3_busy_cycles", busy_cnt, 0);

        // Write then read back with different wait counts
        clear_log();
        issue(1, 5, 'hBEEF, 2, k);
        wait_comp("wr5", k + 3, 0);
        issue(0, 5, 0, 4, j);
        wait_comp("rd5", j + 5, 'hBEEF);

        // Hold freezes the countdown for four WAIT cycles
        clear_log();
        issue(0, 5, 0, 3, k);
        hold = 1'b1;
        repeat (4) step();
        hold = 1'b0;
        wait_comp("hold_rd", k + 8, 'hBEEF);
        chk("hold_busy_cycles", busy_cnt, 7);

        // Overlapping request is dropped
        clear_log();
        issue(1, 2, 'h1234, 5, k);
        step();
        issue(1, 2, 'hFFFF, 0, j);
        wait_comp("ovl_wr", k + 6, 0);
        chk("ovl_count", ovl_cnt, 1);
        chk("ovl_cycle", ovl_cyc, k + 3);
        issue(0, 2, 0, 0, j);
        wait_comp("ovl_rd", j + 1, 'h1234);

        // Abort in the second WAIT cycle
        clear_log();
        issue(1, 7, 'hAAAA, 4, k);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        repeat (8) step();
        chk("abort_no_complete", comp_cyc.size(), 0);
        issue(0, 7, 0, 0, j);
        wait_comp("abort_rd", j + 1, 0);

        // Back-to-back write then read of the same address
        clear_log();
        issue(1, 1, 'h5555, 1, k);
        step();
        issue(0, 1, 0, 0, j);
        wait_comp("b2b_wr", k + 2, 0);
        wait_comp("b2b_rd", k + 3, 'h5555);

        // Reset while in WAIT discards the transaction and the regfile
        clear_log();
        issue(1, 4, 'h4444, 6, k);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("rst_complete", complete_transaction, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", txn_rdata, 0);
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("rst_no_complete", comp_cyc.size(), 0);
        issue(0, 1, 0, 0, j);
        wait_comp("rst_rd1", j + 1, 0);

        // Randomised traffic checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            step();
            start_transaction = ($urandom_range(0, 99) < 35);
            txn_write = 1'($urandom_range(0, 1));
            txn_addr = ADDR_W'($urandom_range(0, 7));
            txn_wdata = DATA_W'($urandom);
            cfg_wait = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            hold = ($urandom_range(0, 99) < 20);
            abort = ($urandom_range(0, 99) < 6);
            reset = ($urandom_range(0, 199) == 0);
        end
        step();
        start_transaction = 1'b0;
        hold = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_txn_responder.md
BUS_TXN_RESPONDER -- requirements
Module: bus_txn_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, address width; DATA_W, default 16, data width; register file depth is 2**ADDR_W.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start_transaction  input  1  single-cycle request strobe from the initiator.
REQ-005 txn_write  input  1  1 = write, 0 = read; sampled with start_transaction.
REQ-006 txn_addr  input  ADDR_W  register index; sampled with start_transaction.
REQ-007 txn_wdata  input  DATA_W  write data; sampled with start_transaction.
REQ-008 cfg_wait  input  3  wait states for this transaction (0-7); sampled with start_transaction.
REQ-009 hold  input  1  freezes the wait-state countdown while high.
REQ-010 abort  input  1  cancels an in-flight transaction, e.g. driven from a watchdog timeout.
REQ-011 complete_transaction  output  1  single-cycle completion strobe to the initiator.
REQ-012 txn_rdata  output  DATA_W  read data, valid only while complete_transaction is high.
REQ-013 busy  output  1  high while the block is in WAIT.
REQ-014 overlap_error  output  1  single-cycle pulse: a request arrived while busy and was dropped.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, WAIT and RESP; all outputs SHALL be registered or decoded from state only.
REQ-016 IDLE or RESP with start_transaction=1: latch write, addr, wdata; load cnt with cfg_wait; next state = RESP if cfg_wait==0, else WAIT.
REQ-017 RESP without start_transaction: next state = IDLE.
REQ-018 WAIT with abort=1: next state = IDLE; drop the latched request; no completion, no register write.
REQ-019 WAIT, abort=0, hold=1: remain in WAIT with cnt unchanged.
REQ-020 WAIT, abort=0, hold=0: decrement cnt; enter RESP on the edge where cnt==1.
REQ-021 Latency: start sampled in cycle k, with hold low throughout -> complete_transaction high in exactly cycle k+1+cfg_wait; each hold-high cycle in WAIT adds one cycle.
REQ-022 complete_transaction SHALL be high for exactly the one cycle spent in RESP.
REQ-023 Read: txn_rdata = regfile[addr] during the RESP cycle.
REQ-024 Write: txn_rdata = 0 during the RESP cycle; regfile[addr] <= wdata at the edge ending RESP.
REQ-025 txn_rdata SHALL be 0 in every cycle outside RESP.
REQ-026 Back-to-back: a start in the RESP cycle SHALL be accepted per REQ-016, and the current transaction SHALL still complete and commit.
REQ-027 A read issued back-to-back after a write to the same address SHALL return the newly written data.
REQ-028 start_transaction in WAIT: the request SHALL be dropped, overlap_error SHALL pulse in the next cycle, and the in-flight transaction SHALL be unaffected.
REQ-029 start_transaction and abort together in WAIT: the abort SHALL take effect and the start SHALL be treated as an overlap per REQ-028.
REQ-030 abort and hold SHALL be ignored in IDLE and RESP.
REQ-031 busy SHALL equal (state==WAIT).

Reset
REQ-032 On reset assertion: state=IDLE; cnt, latched fields and every regfile entry = 0; complete_transaction=0, txn_rdata=0, busy=0, overlap_error=0.
REQ-033 Reset asserted mid-transaction SHALL discard it: no completion is produced and no register write occurs, including when reset arrives in the RESP cycle.

Verification
REQ-034 After reset, read addr 3 with cfg_wait=0 started in cycle k -> complete in cycle k+1, txn_rdata=0x0000, busy never high.
REQ-035 Write addr 5 = 0xBEEF with cfg_wait=2 in cycle k -> complete in cycle k+3; then read addr 5 with cfg_wait=4 in cycle j -> complete in cycle j+5 with rdata=0xBEEF.
REQ-036 Read with cfg_wait=3 and hold high for 4 cycles in WAIT -> complete in cycle k+8; busy high for 7 cycles.
REQ-037 Write addr 2 = 0x1234 with cfg_wait=5; second start (write addr 2 = 0xFFFF) in WAIT -> overlap_error for 1 cycle, complete at k+6, addr 2 reads back 0x1234.
REQ-038 Write addr 7 = 0xAAAA with cfg_wait=4; abort in the 2nd WAIT cycle -> no complete, busy=0 next cycle, addr 7 reads back 0x0000.
REQ-039 Write addr 1 = 0x5555 with cfg_wait=1, then a read of addr 1 (cfg_wait=0) started in its RESP cycle -> two completes in consecutive cycles; the second returns 0x5555. Separately, reset asserted in WAIT -> no complete, all outputs return to 0.
